// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared definitions for the operand forwarding controller: mux4 select
// encoding, tag-pipe stage indices and the hard-wired zero register.
package operand_fwd_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_SEL_RF    = 2'd0,
        FWD_SEL_EXMEM = 2'd1,
        FWD_SEL_MEMWB = 2'd2,
        FWD_SEL_RET   = 2'd3
    } fwd_sel_e;

    localparam int unsigned NUM_STG  = 3;
    localparam int unsigned STG_EX   = 0;
    localparam int unsigned STG_MEM  = 1;
    localparam int unsigned STG_WB   = 2;
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/operand_fwd_ctrl_fwd_match.sv
// Compares one ID source register against the EX/MEM/WB destination tags and
// returns the youngest-producer mux4 select.
module operand_fwd_ctrl_fwd_match
    import operand_fwd_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0]               src,
    input  logic [NUM_STG-1:0]              stg_wr,
    input  logic [NUM_STG-1:0][REG_AW-1:0]  stg_addr,
    output fwd_sel_e                        sel_c,
    output logic                            ex_hit_c
);

    logic [NUM_STG-1:0] hit_c;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_STG; i++) begin
            hit_c[i] = stg_wr[i] && (stg_addr[i] == src) && (src != REG_AW'(REG_ZERO));
        end
        // Youngest producer wins.
        sel_c = FWD_SEL_RF;
        if (hit_c[STG_EX]) begin
            sel_c = FWD_SEL_EXMEM;
        end else if (hit_c[STG_MEM]) begin
            sel_c = FWD_SEL_MEMWB;
        end else if (hit_c[STG_WB]) begin
            sel_c = FWD_SEL_RET;
        end
        ex_hit_c = hit_c[STG_EX];
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Forwarding/hazard controller ahead of the EX operand mux4s: tag pipe,
// registered operand selects, load-use stall. MDU interlock under OPERAND_FWD_MDU_EN.
module operand_fwd_ctrl
    import operand_fwd_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ext,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              id_mdu_start,
    input  logic              id_rd_hilo,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall_id,
    output logic              mdu_busy
);

    // Per-stage tag: wr = valid & wr_en; only the EX stage needs is_load.
    logic [NUM_STG-1:0]             wr_q, wr_d;
    logic [NUM_STG-1:0][REG_AW-1:0] addr_q, addr_d;
    logic                           ex_ld_q, ex_ld_d;
    fwd_sel_e                       fwd_sel_a_q, fwd_sel_a_d;
    fwd_sel_e                       fwd_sel_b_q, fwd_sel_b_d;

    fwd_sel_e sel_a_c, sel_b_c;
    logic     ex_hit_a_c, ex_hit_b_c;
    logic     load_use_c, hilo_stall_c, issue_c;

    operand_fwd_ctrl_fwd_match #(.REG_AW(REG_AW)) u_match_rs (
        .src      (id_rs),
        .stg_wr   (wr_q),
        .stg_addr (addr_q),
        .sel_c    (sel_a_c),
        .ex_hit_c (ex_hit_a_c)
    );

    operand_fwd_ctrl_fwd_match #(.REG_AW(REG_AW)) u_match_rt (
        .src      (id_rt),
        .stg_wr   (wr_q),
        .stg_addr (addr_q),
        .sel_c    (sel_b_c),
        .ex_hit_c (ex_hit_b_c)
    );

    assign load_use_c = id_valid && ex_ld_q && (ex_hit_a_c || ex_hit_b_c);
    assign stall_id   = !flush && (load_use_c || hilo_stall_c);
    assign issue_c    = id_valid && !stall_id;

    // Tag pipe advance and select capture; flush overrides stall_ext.
    always_comb begin
        wr_d        = wr_q;
        addr_d      = addr_q;
        ex_ld_d     = ex_ld_q;
        fwd_sel_a_d = fwd_sel_a_q;
        fwd_sel_b_d = fwd_sel_b_q;
        if (flush) begin
            wr_d        = '0;
            ex_ld_d     = 1'b0;
            fwd_sel_a_d = FWD_SEL_RF;
            fwd_sel_b_d = FWD_SEL_RF;
        end else if (!stall_ext) begin
            wr_d[STG_WB]    = wr_q[STG_MEM];
            addr_d[STG_WB]  = addr_q[STG_MEM];
            wr_d[STG_MEM]   = wr_q[STG_EX];
            addr_d[STG_MEM] = addr_q[STG_EX];
            wr_d[STG_EX]    = issue_c && id_wr_en;
            addr_d[STG_EX]  = id_wr_addr;
            ex_ld_d         = issue_c && id_is_load;
            fwd_sel_a_d     = issue_c ? sel_a_c : FWD_SEL_RF;
            fwd_sel_b_d     = issue_c ? sel_b_c : FWD_SEL_RF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q        <= '0;
            addr_q      <= '0;
            ex_ld_q     <= 1'b0;
            fwd_sel_a_q <= FWD_SEL_RF;
            fwd_sel_b_q <= FWD_SEL_RF;
        end else begin
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            ex_ld_q     <= ex_ld_d;
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
        end
    end

    assign fwd_sel_a = fwd_sel_a_q;
    assign fwd_sel_b = fwd_sel_b_q;

`ifdef OPERAND_FWD_MDU_EN
    localparam int unsigned CNT_W = $clog2(MDU_LAT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdu_busy_q, mdu_busy_d;

    // A start (re)loads the full latency; a squashed start in a flush cycle does not.
    always_comb begin
        cnt_d = cnt_q;
        if (!stall_ext) begin
            if (id_mdu_start && !stall_id && !flush) begin
                cnt_d = CNT_W'(MDU_LAT);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        mdu_busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            mdu_busy_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mdu_busy_q <= mdu_busy_d;
        end
    end

    assign hilo_stall_c = id_rd_hilo && mdu_busy_q;
    assign mdu_busy     = mdu_busy_q;
`else
    logic mdu_unused_c;

    assign mdu_unused_c = ^{id_mdu_start, id_rd_hilo, 1'(MDU_LAT)};
    assign hilo_stall_c = 1'b0;
    assign mdu_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: stimulus queues per-cycle expectations,
// a monitor pops them mid-cycle and compares selects, stall and busy.
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall_ext, flush, id_valid;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic       id_wr_en, id_is_load, id_mdu_start, id_rd_hilo;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       stall_id, mdu_busy;

    typedef struct {
        string      name;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       stall;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rst_cmd = 1'b0;

    always #5 clk = ~clk;

    operand_fwd_ctrl #(.REG_AW(5), .MDU_LAT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_ext    (stall_ext),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wr_en     (id_wr_en),
        .id_wr_addr   (id_wr_addr),
        .id_is_load   (id_is_load),
        .id_mdu_start (id_mdu_start),
        .id_rd_hilo   (id_rd_hilo),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_id     (stall_id),
        .mdu_busy     (mdu_busy)
    );

    task automatic chk(input string nm, input string what, input logic [1:0] act, input logic [1:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One ID cycle: drive inputs and queue what the DUT must show this cycle
    // (selects/busy reflect the previous edge, stall is combinational now).
    task automatic cyc(input string nm, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic wr, input logic [4:0] wa, input logic ld, input logic md,
                       input logic hl, input logic se, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb, input logic es, input logic ebz);
        exp_t e;
        @(negedge clk);
        #1;
        rst          = rst_cmd;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_wr_en     = wr;
        id_wr_addr   = wa;
        id_is_load   = ld;
        id_mdu_start = md;
        id_rd_hilo   = hl;
        stall_ext    = se;
        flush        = fl;
        e.name  = nm;
        e.sel_a = ea;
        e.sel_b = eb;
        e.stall = es;
        e.busy  = ebz;
        sb_q.push_back(e);
    endtask

    task automatic nop(input string nm, input logic [1:0] ea, input logic [1:0] eb);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, 0);
    endtask

    task automatic drain();
        repeat (3) nop("drain", 0, 0);
    endtask

    // Monitor: compares each queued expectation mid-cycle, after inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk(e.name, "sel_a", fwd_sel_a, e.sel_a);
                chk(e.name, "sel_b", fwd_sel_b, e.sel_b);
                chk(e.name, "stall", 2'(stall_id), 2'(e.stall));
                chk(e.name, "busy",  2'(mdu_busy), 2'(e.busy));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rst_cmd = 1'b0;
        {stall_ext, flush, id_valid, id_wr_en, id_is_load, id_mdu_start, id_rd_hilo} = '0;
        id_rs = '0; id_rt = '0; id_wr_addr = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        nop("reset", 0, 0);

        // add $3 ; sub $4,$3,$5
        cyc("t1_add", 1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t1_sub", 1, 3, 5, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("t1_sub_ex", 1, 0);
        drain();

        // lw $8 ; add $9,$8,$8 -> one stall cycle, then MEM/WB forward
        cyc("t2_lw",        1, 1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t2_use_stall", 1, 8, 8, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("t2_use_go",    1, 8, 8, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("t2_add_ex", 2, 2);
        drain();

        // $0 is never forwarded, even from a load
        cyc("t3_add0", 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_lw0",  1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_rd0",  1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("t3_rd0_ex", 0, 0);
        drain();

        // $6 written at distances 1,2,3, then distance 2 and 3 alone
        cyc("t4_w6a",     1, 1, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_w6b",     1, 1, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_w6c",     1, 1, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_rd_d123", 1, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("t4_sel_young", 1, 0);
        cyc("t4_w6",      1, 1, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("t4_gap", 0, 0);
        cyc("t4_rd_d2",   1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_rd_d3",   1, 7, 6, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        nop("t4_sel_d3", 0, 3);
        drain();

        // stall_ext holds tags and selects for 4 cycles
        cyc("t5_w10",  1, 1, 2, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_rd10", 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("t5_ext_hold", 1, 10, 11, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        end
        cyc("t5_ext_rel", 1, 10, 11, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nop("t5_after", 2, 0);

        // load-use still stalls under stall_ext; flush wins and clears everything
        cyc("t5_w13",        1, 1, 2, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_lw12",       1, 13, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_ext_ld",     1, 12, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
        cyc("t5_flush",      1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc("t5_post_flush", 1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("t5_post_ex", 0, 0);
        drain();

        // div then mflo
        cyc("t6_div", 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef OPERAND_FWD_MDU_EN
        for (int i = 0; i < 4; i++) begin
            cyc("t6_mflo_wait", 1, 0, 0, 1, 14, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        end
`endif
        cyc("t6_mflo_go", 1, 0, 0, 1, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        nop("t6_end", 0, 0);
        drain();

        // asynchronous reset releases a pending load-use stall at once
        cyc("r_lw15",  1, 1, 0, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("r_stall", 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_cmd = 1'b1;
        cyc("r_async", 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_cmd = 1'b0;
        cyc("r_after", 1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop("r_end", 0, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
